// File: rtl/soc_cfg_regbank_pkg.sv
// Shared register map, CTRL bit positions and APB response type for soc_cfg_regbank.
// Pure definitions: no latency and no backpressure of its own.
package soc_cfg_regbank_pkg;

    localparam logic [11:0] REG_ID      = 12'h000;
    localparam logic [11:0] REG_GEOM    = 12'h004;
    localparam logic [11:0] REG_CTRL    = 12'h008;
    localparam logic [11:0] REG_STATUS  = 12'h00C;
    localparam logic [11:0] REG_SHADOW0 = 12'h010;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_LOCK   = 1;
    localparam int MAX_NCH     = 8;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

endpackage

// File: rtl/soc_cfg_regbank_if.sv
// APB request/response bundle between the peripheral bus and soc_cfg_regbank.
// Wires only: no latency; completion is signalled by pready.
interface soc_cfg_regbank_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/soc_cfg_chan.sv
// One config channel: shadow, pending offer and active value; updates one cycle after the strobe.
// Pending value and valid hold until the consumer raises ready; ready without valid is ignored.
module soc_cfg_chan #(
    parameter int             DW      = 8,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          shadow_we,
    input  logic [DW-1:0] shadow_wdata,
    input  logic          offer,
    input  logic          ready,
    output logic [DW-1:0] shadow,
    output logic [DW-1:0] pend,
    output logic [DW-1:0] active,
    output logic          valid
);
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] pend_q, pend_d;
    logic [DW-1:0] active_q, active_d;
    logic          valid_q, valid_d;

    always_comb begin
        shadow_d = shadow_q;
        pend_d   = pend_q;
        active_d = active_q;
        valid_d  = valid_q;
        if (shadow_we) shadow_d = shadow_wdata;
        if (valid_q && ready) begin
            active_d = pend_q;
            valid_d  = 1'b0;
        end
        // offer is only raised while no channel is pending, so it never races a retire
        if (offer) begin
            pend_d  = shadow_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q <= RST_VAL;
            pend_q   <= RST_VAL;
            active_q <= RST_VAL;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    assign shadow = shadow_q;
    assign pend   = pend_q;
    assign active = active_q;
    assign valid  = valid_q;
endmodule

// File: rtl/soc_cfg_regbank.sv
// APB config register bank with atomic commit to NCH channels; one APB wait state per access.
// Per-channel valid/ready offer; optional sticky write lock when SOC_CFG_REGBANK_LOCK_EN is defined.
module soc_cfg_regbank
    import soc_cfg_regbank_pkg::*;
#(
    parameter int             NCH     = 4,
    parameter int             DW      = 8,
    parameter logic [31:0]    HW_ID   = 32'h20221101,
    parameter logic [31:0]    GEOM    = 32'h0,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    soc_cfg_regbank_if.slave      apb,
    output logic [NCH*DW-1:0]     o_cfg_data,
    output logic [NCH-1:0]        o_cfg_valid,
    input  logic [NCH-1:0]        i_cfg_ready,
    output logic [NCH*DW-1:0]     o_cfg_active
);
    logic [NCH-1:0][DW-1:0] shadow, pend, active;
    logic [NCH-1:0]         valid, shadow_we, offer;
    logic                   access, commit_go, lock;
    logic                   pready_q, pready_d;
    apb_resp_t              resp_q, resp_d;
    logic [9:0]             word;
    logic                   unused_apb_bits;

`ifdef SOC_CFG_REGBANK_LOCK_EN
    logic lock_set, lock_q, lock_d;
    always_comb lock_d = lock_q | lock_set;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    assign word            = apb.paddr[11:2];
    assign unused_apb_bits = ^{apb.paddr, apb.pwdata};
    assign access          = apb.psel & apb.penable & ~pready_q;

    always_comb begin
        resp_d    = '0;
        pready_d  = access;
        shadow_we = '0;
        commit_go = 1'b0;
`ifdef SOC_CFG_REGBANK_LOCK_EN
        lock_set  = 1'b0;
`endif
        if (access) begin
            if (word == REG_ID[11:2]) begin
                if (apb.pwrite) resp_d.pslverr = 1'b1;
                else            resp_d.prdata  = HW_ID;
            end else if (word == REG_GEOM[11:2]) begin
                if (apb.pwrite) resp_d.pslverr = 1'b1;
                else            resp_d.prdata  = GEOM;
            end else if (word == REG_CTRL[11:2]) begin
                if (apb.pwrite) begin
                    if (apb.pwdata[CTRL_COMMIT]) begin
                        if (lock || (|valid)) resp_d.pslverr = 1'b1;
                        else                  commit_go      = 1'b1;
                    end
`ifdef SOC_CFG_REGBANK_LOCK_EN
                    lock_set = apb.pwdata[CTRL_LOCK];
`endif
                end else begin
                    resp_d.prdata[CTRL_LOCK] = lock;
                end
            end else if (word == REG_STATUS[11:2]) begin
                if (apb.pwrite) resp_d.pslverr            = 1'b1;
                else            resp_d.prdata[NCH-1:0]    = valid;
            end else begin
                // anything not matching a shadow slot below stays an error
                resp_d.pslverr = 1'b1;
                for (int n = 0; n < NCH; n++) begin
                    if (word == REG_SHADOW0[11:2] + 10'(n)) begin
                        resp_d.pslverr = 1'b0;
                        if (apb.pwrite) begin
                            if (lock || valid[n]) resp_d.pslverr = 1'b1;
                            else                  shadow_we[n]   = 1'b1;
                        end else begin
                            resp_d.prdata[DW-1:0] = shadow[n];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pready_q <= 1'b0;
            resp_q   <= '0;
        end else begin
            pready_q <= pready_d;
            resp_q   <= resp_d;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        assign offer[n] = commit_go & (shadow[n] != active[n]) & ~valid[n];

        soc_cfg_chan #(
            .DW      (DW),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .shadow_we    (shadow_we[n]),
            .shadow_wdata (apb.pwdata[DW-1:0]),
            .offer        (offer[n]),
            .ready        (i_cfg_ready[n]),
            .shadow       (shadow[n]),
            .pend         (pend[n]),
            .active       (active[n]),
            .valid        (valid[n])
        );
    end

    assign apb.prdata   = resp_q.prdata;
    assign apb.pslverr  = resp_q.pslverr;
    assign apb.pready   = pready_q;
    assign o_cfg_data   = pend;
    assign o_cfg_valid  = valid;
    assign o_cfg_active = active;
endmodule

// File: tb/tb_soc_cfg_regbank.sv
// Bench for soc_cfg_regbank: directed register-map scenarios, then random APB/ready traffic
// compared every cycle against an array-based model of the register bank.
module tb_soc_cfg_regbank;
    localparam int            NCH    = 4;
    localparam int            DW     = 8;
    localparam logic [31:0]   ID_V   = 32'h20221101;
    localparam logic [31:0]   GEOM_V = 32'h0103_0A0B;
    localparam logic [DW-1:0] RSTV   = 8'h00;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] cfg_data, cfg_active;
    logic [NCH-1:0]    cfg_valid, cfg_ready;

    soc_cfg_regbank_if bus();

    soc_cfg_regbank #(
        .NCH(NCH), .DW(DW), .HW_ID(ID_V), .GEOM(GEOM_V), .RST_VAL(RSTV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .apb          (bus),
        .o_cfg_data   (cfg_data),
        .o_cfg_valid  (cfg_valid),
        .i_cfg_ready  (cfg_ready),
        .o_cfg_active (cfg_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_shadow [NCH];
    logic [DW-1:0] m_pend   [NCH];
    logic [DW-1:0] m_active [NCH];
    bit            m_valid  [NCH];
    bit            m_lock;
    bit            m_pready;
    logic [31:0]   m_prdata;
    bit            m_pslverr;

    function automatic void model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_shadow[n] = RSTV;
            m_pend[n]   = RSTV;
            m_active[n] = RSTV;
            m_valid[n]  = 1'b0;
        end
        m_lock    = 1'b0;
        m_pready  = 1'b0;
        m_prdata  = '0;
        m_pslverr = 1'b0;
    endfunction

    function automatic void model_step();
        bit          acc;
        bit          old_v [NCH];
        bit          any_v;
        int          w;
        int          ch;
        logic [31:0] d;
        acc   = bus.psel && bus.penable && !m_pready;
        any_v = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            old_v[n] = m_valid[n];
            any_v    = any_v | m_valid[n];
        end
        m_prdata  = '0;
        m_pslverr = 1'b0;
        if (acc) begin
            w  = int'(bus.paddr) / 4;
            d  = bus.pwdata;
            ch = w - 4;
            if (w == 0 || w == 1 || w == 3) begin
                if (bus.pwrite) m_pslverr = 1'b1;
                else if (w == 0) m_prdata = ID_V;
                else if (w == 1) m_prdata = GEOM_V;
                else for (int n = 0; n < NCH; n++) m_prdata[n] = m_valid[n];
            end else if (w == 2) begin
                if (!bus.pwrite) m_prdata = m_lock ? 32'd2 : 32'd0;
                else begin
                    if (d[0]) begin
                        if (m_lock || any_v) m_pslverr = 1'b1;
                        else for (int n = 0; n < NCH; n++)
                            if (m_shadow[n] != m_active[n]) begin
                                m_pend[n]  = m_shadow[n];
                                m_valid[n] = 1'b1;
                            end
                    end
`ifdef SOC_CFG_REGBANK_LOCK_EN
                    if (d[1]) m_lock = 1'b1;
`endif
                end
            end else if (ch >= 0 && ch < NCH) begin
                if (!bus.pwrite) m_prdata = 32'(m_shadow[ch]);
                else if (m_lock || old_v[ch]) m_pslverr = 1'b1;
                else m_shadow[ch] = d[DW-1:0];
            end else begin
                m_pslverr = 1'b1;
            end
        end
        for (int n = 0; n < NCH; n++)
            if (cfg_ready[n] && old_v[n]) begin
                m_active[n] = m_pend[n];
                m_valid[n]  = 1'b0;
            end
        m_pready = acc;
    endfunction

    always @(posedge clk) if (!rst) model_step();

    always @(negedge clk) begin
        chk("pready", 32'(bus.pready), 32'(m_pready));
        if (m_pready) begin
            chk("prdata", bus.prdata, m_prdata);
            chk("pslverr", 32'(bus.pslverr), 32'(m_pslverr));
        end
        for (int n = 0; n < NCH; n++) begin
            chk($sformatf("valid%0d", n), 32'(cfg_valid[n]), 32'(m_valid[n]));
            chk($sformatf("active%0d", n), 32'(cfg_active[n*DW +: DW]), 32'(m_active[n]));
            if (m_valid[n]) chk($sformatf("data%0d", n), 32'(cfg_data[n*DW +: DW]), 32'(m_pend[n]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output logic err, output int waits);
        bus.psel    = 1'b1;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        bus.penable = 1'b0;
        cycles(1);
        bus.penable = 1'b1;
        waits = 0;
        do begin
            cycles(1);
            waits++;
        end while (!bus.pready && waits < 8);
        if (!bus.pready) chk("apb_timeout", 32'd0, 32'd1);
        rdat = bus.prdata;
        err  = bus.pslverr;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    logic [11:0] addr_tab [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                   12'h014, 12'h018, 12'h01C, 12'h020, 12'h400};

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;
        logic [11:0] a;
        logic [31:0] d;
        rst         = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        cfg_ready   = '0;
        model_reset();
        cycles(3);
        chk("rst_valid", 32'(cfg_valid), 32'h0);
        chk("rst_active", 32'(cfg_active), 32'h0);
        chk("rst_prdata", bus.prdata, 32'h0);
        rst = 1'b0;
        cycles(1);

        apb(0, 12'h000, 0, rd, er, wt);
        chk("id_data", rd, 32'h20221101);
        chk("id_err", 32'(er), 0);
        chk("id_waits", 32'(wt), 1);
        apb(0, 12'h004, 0, rd, er, wt);
        chk("geom_data", rd, 32'h0103_0A0B);

        apb(1, 12'h018, 32'h5A, rd, er, wt);
        chk("sh2_err", 32'(er), 0);
        apb(1, 12'h008, 32'h1, rd, er, wt);
        chk("commit_err", 32'(er), 0);
        chk("commit_valid", 32'(cfg_valid), 32'h4);
        chk("commit_data", 32'(cfg_data[23:16]), 32'h5A);
        cycles(3);
        chk("hold_valid", 32'(cfg_valid), 32'h4);
        cfg_ready = 4'b0100;
        cycles(1);
        cfg_ready = '0;
        chk("ret_active", 32'(cfg_active[23:16]), 32'h5A);
        chk("ret_valid", 32'(cfg_valid), 32'h0);

        apb(1, 12'h010, 32'h33, rd, er, wt);
        apb(1, 12'h008, 32'h1, rd, er, wt);
        chk("c0_valid", 32'(cfg_valid), 32'h1);
        apb(1, 12'h010, 32'h11, rd, er, wt);
        chk("sh0_busy_err", 32'(er), 1);
        apb(0, 12'h010, 0, rd, er, wt);
        chk("sh0_kept", rd, 32'h33);
        apb(1, 12'h008, 32'h1, rd, er, wt);
        chk("commit_busy_err", 32'(er), 1);
        chk("c0_data", 32'(cfg_data[7:0]), 32'h33);
        cfg_ready = 4'b0001;
        cycles(1);
        cfg_ready = '0;
        chk("c0_active", 32'(cfg_active[7:0]), 32'h33);

        apb(0, 12'h400, 0, rd, er, wt);
        chk("bad_rd_err", 32'(er), 1);
        chk("bad_rd_data", rd, 32'h0);
        apb(1, 12'h004, 32'hDEAD_BEEF, rd, er, wt);
        chk("ro_wr_err", 32'(er), 1);
        apb(0, 12'h004, 0, rd, er, wt);
        chk("geom_kept", rd, 32'h0103_0A0B);

        apb(1, 12'h008, 32'h1, rd, er, wt);
        chk("noop_commit_err", 32'(er), 0);
        chk("noop_commit_valid", 32'(cfg_valid), 32'h0);

`ifdef SOC_CFG_REGBANK_LOCK_EN
        apb(1, 12'h008, 32'h2, rd, er, wt);
        chk("lock_wr_err", 32'(er), 0);
        apb(0, 12'h008, 0, rd, er, wt);
        chk("lock_rd", rd, 32'h2);
        apb(1, 12'h014, 32'h22, rd, er, wt);
        chk("locked_sh_err", 32'(er), 1);
        apb(1, 12'h008, 32'h1, rd, er, wt);
        chk("locked_commit_err", 32'(er), 1);
        do_reset();
        apb(0, 12'h008, 0, rd, er, wt);
        chk("unlock_rd", rd, 32'h0);
        chk("unlock_active", 32'(cfg_active), 32'h0);
`else
        apb(1, 12'h008, 32'h2, rd, er, wt);
        chk("nolock_wr_err", 32'(er), 0);
        apb(0, 12'h008, 0, rd, er, wt);
        chk("nolock_rd", rd, 32'h0);
`endif

        do_reset();
        repeat (1500) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    cfg_ready = NCH'($urandom);
                    cycles($urandom_range(1, 3));
                    cfg_ready = '0;
                end
                default: begin
                    if ($urandom_range(0, 199) == 0) do_reset();
                    cfg_ready = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
                    a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 9)];
                    if (a[11:2] == 10'd2)
                        d = ($urandom_range(0, 49) == 0) ? 32'h3 : 32'($urandom_range(0, 1));
                    else
                        d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    apb($urandom_range(0, 1) == 1, a, d, rd, er, wt);
                    cfg_ready = '0;
                end
            endcase
        end
        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
